// File: rtl/alu_issue_pkg.sv
// Shared definitions for the ALU issue block: instruction layout, opcodes,
// FSM encoding and SREG flag positions.
package alu_issue_pkg;

  localparam int INSTR_W  = 16;
  localparam int DATA_W   = 8;
  localparam int NUM_REGS = 4;
  localparam int ADDR_W   = 2;

  localparam int OPC_HI = 15;
  localparam int OPC_LO = 12;
  localparam int RD_HI  = 11;
  localparam int RD_LO  = 10;
  localparam int RS_HI  = 9;
  localparam int RS_LO  = 8;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;

  // opcode[3] marks the reserved half of the opcode space; opcode[2] picks imm8 as B
  localparam int OPC_ILLEGAL_BIT = 3;
  localparam int OPC_IMM_BIT     = 2;

  localparam logic [3:0] OP_AND  = 4'h0;
  localparam logic [3:0] OP_OR   = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_ANDI = 4'h4;
  localparam logic [3:0] OP_ORI  = 4'h5;
  localparam logic [3:0] OP_ADDI = 4'h6;
  localparam logic [3:0] OP_SUBI = 4'h7;

  localparam int SREG_Z = 5;
  localparam int SREG_V = 6;
  localparam int SREG_N = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WB    = 2'd2
  } state_t;

  typedef struct packed {
    logic [OPC_HI:OPC_LO] opcode;
    logic [RD_HI:RD_LO]   rd;
    logic [RS_HI:RS_LO]   rs;
    logic [IMM_HI:IMM_LO] imm;
  } instr_t;

  function automatic logic is_legal(input logic [3:0] op);
    return !op[OPC_ILLEGAL_BIT];
  endfunction

  function automatic logic uses_imm(input logic [3:0] op);
    return op[OPC_IMM_BIT];
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// 4x8 register file: one synchronous write port, two combinational read
// ports for operand fetch and a combinational debug read port.
module alu_regfile
  import alu_issue_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  input  logic [ADDR_W-1:0] dbg_sel,
  output logic [DATA_W-1:0] dbg_data
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a  = regs[raddr_a];
  assign rdata_b  = regs[raddr_b];
  assign dbg_data = regs[dbg_sel];

endmodule

// File: rtl/alu_issue.sv
// Issue controller in front of an external registered ALU: fetches operands,
// holds them through ISSUE/WB and writes the ALU result and flags back.
module alu_issue
  import alu_issue_pkg::*;
#(
  parameter logic [7:0] SREG_INIT = 8'h00
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [INSTR_W-1:0]  instr,
  input  logic                instr_valid,
  output logic                instr_ready,
  output logic [DATA_W-1:0]   a,
  output logic [DATA_W-1:0]   b,
  output logic [3:0]          opcode,
  output logic [DATA_W-1:0]   sreg1_o,
  input  logic [DATA_W-1:0]   alu_out,
  input  logic [DATA_W-1:0]   alu_sreg,
  output logic                done,
  output logic                err,
  input  logic [ADDR_W-1:0]   dbg_sel,
  output logic [DATA_W-1:0]   dbg_data
);

  state_t            state;
  instr_t            fields;
  logic [ADDR_W-1:0] rd_q;
  logic [DATA_W-1:0] sreg;
  logic [DATA_W-1:0] rdata_a;
  logic [DATA_W-1:0] rdata_b;
  logic              wb_we;
  logic              accept;

  assign fields      = instr_t'(instr);
  assign instr_ready = (state == ST_IDLE);
  assign accept      = instr_ready && instr_valid;
  assign wb_we       = (state == ST_WB);
  assign sreg1_o     = sreg;

  alu_regfile u_regfile (
    .clk      (clk),
    .rst      (rst),
    .we       (wb_we),
    .waddr    (rd_q),
    .wdata    (alu_out),
    .raddr_a  (fields.rd),
    .raddr_b  (fields.rs),
    .rdata_a  (rdata_a),
    .rdata_b  (rdata_b),
    .dbg_sel  (dbg_sel),
    .dbg_data (dbg_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      a      <= '0;
      b      <= '0;
      opcode <= '0;
      rd_q   <= '0;
      sreg   <= SREG_INIT;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (is_legal(fields.opcode)) begin
              a      <= rdata_a;
              b      <= uses_imm(fields.opcode) ? fields.imm : rdata_b;
              opcode <= fields.opcode;
              rd_q   <= fields.rd;
              state  <= ST_ISSUE;
            end else begin
              err <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          // the ALU captures a/b/opcode at this edge; its result is valid during WB
          state <= ST_WB;
          done  <= 1'b1;
        end
        ST_WB: begin
          sreg  <= alu_sreg;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: directed table, corner sequences and
// random instructions against an architectural register/flag model.
module tb_alu_issue;
  import alu_issue_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] instr = '0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [7:0]  a, b, sreg1_o, alu_out, alu_sreg, dbg_data;
  logic [3:0]  opcode;
  logic        done, err;
  logic [1:0]  dbg_sel = '0;

  int checks = 0;
  int errors = 0;

  logic [7:0] ref_r [4];
  logic [7:0] ref_sreg;

  alu_issue #(.SREG_INIT(8'h00)) dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .a(a), .b(b), .opcode(opcode),
    .sreg1_o(sreg1_o), .alu_out(alu_out), .alu_sreg(alu_sreg),
    .done(done), .err(err), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // returns {result, new_sreg} for an 8-bit AND/OR/ADD/SUB with Z/V/N flags
  function automatic logic [15:0] alu_fn(input logic [3:0] op, input logic [7:0] x,
                                         input logic [7:0] y, input logic [7:0] s);
    logic [7:0] r;
    logic [7:0] ns;
    logic       v;
    v = 1'b0;
    case (op[1:0])
      2'd0: r = x & y;
      2'd1: r = x | y;
      2'd2: begin r = x + y; v = (x[7] == y[7]) && (r[7] != x[7]); end
      default: begin r = x - y; v = (x[7] != y[7]) && (r[7] != x[7]); end
    endcase
    ns = s;
    ns[SREG_Z] = (r == 8'h00);
    ns[SREG_V] = v;
    ns[SREG_N] = r[7];
    return {r, ns};
  endfunction

  // external registered ALU stub
  always @(posedge clk) begin
    logic [15:0] res;
    res = alu_fn(opcode, a, b, sreg1_o);
    alu_out  <= res[15:8];
    alu_sreg <= res[7:0];
  end

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) ref_r[i] = 8'h00;
    ref_sreg = 8'h00;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // issue one instruction through the full handshake, checking protocol and model
  task automatic issue(input logic [15:0] ins);
    logic [3:0]  op;
    logic [1:0]  rd, rs;
    logic [7:0]  x, y;
    logic [15:0] res;
    op = ins[15:12];
    rd = ins[11:10];
    rs = ins[9:8];
    @(negedge clk);
    chk("ready_before", 16'(instr_ready), 16'h1);
    instr = ins;
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    instr = 16'($urandom);
    @(negedge clk);
    if (op[3]) begin
      chk("err_pulse", 16'(err), 16'h1);
      chk("err_no_done", 16'(done), 16'h0);
      chk("err_ready", 16'(instr_ready), 16'h1);
      @(negedge clk);
      chk("err_one_cycle", 16'(err), 16'h0);
      chk("err_no_done2", 16'(done), 16'h0);
      chk("err_sreg", 16'(sreg1_o), 16'(ref_sreg));
      dbg_sel = rd;
      #1;
      chk("err_reg", 16'(dbg_data), 16'(ref_r[rd]));
    end else begin
      x = ref_r[rd];
      y = op[2] ? ins[7:0] : ref_r[rs];
      chk("issue_a", 16'(a), 16'(x));
      chk("issue_b", 16'(b), 16'(y));
      chk("issue_op", 16'(opcode), 16'(op));
      chk("issue_busy", 16'(instr_ready), 16'h0);
      chk("issue_no_done", 16'(done), 16'h0);
      @(negedge clk);
      chk("wb_done", 16'(done), 16'h1);
      chk("wb_a_stable", 16'(a), 16'(x));
      res = alu_fn(op, x, y, ref_sreg);
      ref_r[rd] = res[15:8];
      ref_sreg  = res[7:0];
      @(negedge clk);
      chk("after_done", 16'(done), 16'h0);
      chk("after_ready", 16'(instr_ready), 16'h1);
      dbg_sel = rd;
      #1;
      chk("wb_reg", 16'(dbg_data), 16'(ref_r[rd]));
      chk("wb_sreg", 16'(sreg1_o), 16'(ref_sreg));
    end
  endtask

  typedef struct {
    logic [15:0] ins;
    logic [1:0]  reg_sel;
    logic [7:0]  exp_reg;
    logic [7:0]  exp_sreg;
  } vec_t;

  vec_t vecs [10];

  initial begin
    int n;
    logic [3:0] rop;

    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [3:0] rop;

    vecs[0] = '{16'h6405, 2'd1, 8'h05, 8'h00};
    vecs[1] = '{16'h64FF, 2'd1, 8'h04, 8'h00};
    vecs[2] = '{16'h6810, 2'd2, 8'h10, 8'h00};
    vecs[3] = '{16'h3A00, 2'd2, 8'h00, 8'h20};
    vecs[4] = '{16'h9000, 2'd0, 8'h00, 8'h20};
    vecs[5] = '{16'h2D00, 2'd3, 8'h04, 8'h00};
    vecs[6] = '{16'h5080, 2'd0, 8'h80, 8'h80};
    vecs[7] = '{16'h0300, 2'd0, 8'h00, 8'h20};
    vecs[8] = '{16'h647F, 2'd1, 8'h83, 8'hC0};
    vecs[9] = '{16'h7C85, 2'd3, 8'h7F, 8'h00};

    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_ready", 16'(instr_ready), 16'h1);
    chk("rst_sreg", 16'(sreg1_o), 16'h00);
    chk("rst_a", 16'(a), 16'h0);
    chk("rst_b", 16'(b), 16'h0);
    chk("rst_op", 16'(opcode), 16'h0);
    chk("rst_done", 16'(done), 16'h0);
    chk("rst_err", 16'(err), 16'h0);
    for (int i = 0; i < 4; i++) begin
      dbg_sel = 2'(i);
      #1;
      chk("rst_reg", 16'(dbg_data), 16'h0);
    end

    for (int i = 0; i < 10; i++) begin
      issue(vecs[i].ins);
      dbg_sel = vecs[i].reg_sel;
      #1;
      chk("vec_reg", 16'(dbg_data), 16'(vecs[i].exp_reg));
      chk("vec_sreg", 16'(sreg1_o), 16'(vecs[i].exp_sreg));
    end

    // back-to-back dependent pair with instr_valid held high
    do_reset();
    @(negedge clk);
    instr = 16'h6811;
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr = 16'h2A00;
    n = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (instr_ready) begin
        n = k;
        break;
      end
    end
    chk("b2b_gap", 16'(n), 16'd3);
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    @(negedge clk);
    chk("b2b_a", 16'(a), 16'h11);
    chk("b2b_b", 16'(b), 16'h11);
    @(negedge clk);
    @(negedge clk);
    dbg_sel = 2'd2;
    #1;
    chk("b2b_result", 16'(dbg_data), 16'h22);

    // reset while ADDI R0,#1 sits in ISSUE
    do_reset();
    @(negedge clk);
    instr = 16'h6001;
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_busy", 16'(instr_ready), 16'h0);
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", 16'(instr_ready), 16'h1);
    chk("mid_rst_a", 16'(a), 16'h0);
    chk("mid_rst_done", 16'(done), 16'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("abandon_no_done", 16'(done), 16'h0);
    end
    dbg_sel = 2'd0;
    #1;
    chk("abandon_r0", 16'(dbg_data), 16'h0);
    chk("abandon_ready", 16'(instr_ready), 16'h1);

    // random instructions against the model
    do_reset();
    for (int i = 0; i < 150; i++) begin
      rop = 4'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) rop[3] = 1'b1;
      issue({rop, 12'($urandom)});
    end
    for (int i = 0; i < 4; i++) begin
      dbg_sel = 2'(i);
      #1;
      chk("final_reg", 16'(dbg_data), 16'(ref_r[i]));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
